// File: rtl/uart_cmd_host.sv
// Host-side initiator for the UART register/ALU command protocol: serialises one
// command into its byte frame, streams it to a UART TX and gathers the response bytes.
module uart_cmd_host #(
  parameter int Data_width        = 8,
  parameter int DEPTH             = 16,
  parameter int NUM_OF_OPERATIONS = 16,
  parameter int TIMEOUT           = 4096
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [1:0]                           cmd_type,
  input  logic [$clog2(DEPTH)-1:0]             cmd_addr,
  input  logic [Data_width-1:0]                cmd_wdata,
  input  logic [Data_width-1:0]                cmd_opa,
  input  logic [Data_width-1:0]                cmd_opb,
  input  logic [$clog2(NUM_OF_OPERATIONS)-1:0] cmd_fun,
  output logic [Data_width-1:0]                tx_data,
  output logic                                 tx_valid,
  input  logic                                 tx_ready,
  input  logic [Data_width-1:0]                rx_data,
  input  logic                                 rx_valid,
  output logic [2*Data_width-1:0]              rsp_data,
  output logic                                 done,
  output logic                                 rsp_timeout,
  output logic                                 rx_unexp
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(NUM_OF_OPERATIONS);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] CMD_WR      = 2'd0;
  localparam logic [1:0] CMD_RD      = 2'd1;
  localparam logic [1:0] CMD_ALU_OP  = 2'd2;
  localparam logic [1:0] CMD_ALU_NOP = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              type_q, type_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [Data_width-1:0]   wdata_q, wdata_d;
  logic [Data_width-1:0]   opa_q, opa_d;
  logic [Data_width-1:0]   opb_q, opb_d;
  logic [FW-1:0]           fun_q, fun_d;
  logic [2*Data_width-1:0] rsp_data_q, rsp_data_d;
  logic                    done_q, done_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    rx_unexp_q, rx_unexp_d;

  logic [Data_width-1:0]   frame_byte;
  logic                    last_byte;
  logic [1:0]              rsp_cnt;
  logic [Data_width-1:0]   addr_ext, fun_ext;

  assign addr_ext = {{(Data_width-AW){1'b0}}, addr_q};
  assign fun_ext  = {{(Data_width-FW){1'b0}}, fun_q};

  // Frame byte and response length decoded from the captured command and byte index.
  always_comb begin
    frame_byte = '0;
    last_byte  = 1'b0;
    rsp_cnt    = 2'd0;
    case (type_q)
      CMD_WR: begin
        case (idx_q)
          2'd0:    frame_byte = Data_width'(8'hAA);
          2'd1:    frame_byte = addr_ext;
          default: frame_byte = wdata_q;
        endcase
        last_byte = (idx_q == 2'd2);
        rsp_cnt   = 2'd0;
      end
      CMD_RD: begin
        frame_byte = (idx_q == 2'd0) ? Data_width'(8'hBB) : addr_ext;
        last_byte  = (idx_q == 2'd1);
        rsp_cnt    = 2'd1;
      end
      CMD_ALU_OP: begin
        case (idx_q)
          2'd0:    frame_byte = Data_width'(8'hCC);
          2'd1:    frame_byte = opa_q;
          2'd2:    frame_byte = opb_q;
          default: frame_byte = fun_ext;
        endcase
        last_byte = (idx_q == 2'd3);
        rsp_cnt   = 2'd2;
      end
      default: begin
        frame_byte = (idx_q == 2'd0) ? Data_width'(8'hDD) : fun_ext;
        last_byte  = (idx_q == 2'd1);
        rsp_cnt    = 2'd2;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    type_d        = type_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    fun_d         = fun_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    done_d        = 1'b0;
    rx_unexp_d    = rx_valid && (state_q != ST_WAIT);
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          type_d        = cmd_type;
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          opa_d         = cmd_opa;
          opb_d         = cmd_opb;
          fun_d         = cmd_fun;
          idx_d         = 2'd0;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (last_byte) begin
            // idx is reused as the received-byte count while waiting
            idx_d = 2'd0;
            cnt_d = '0;
            if (rsp_cnt == 2'd0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_WAIT: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (idx_q == 2'd0) rsp_data_d[Data_width-1:0] = rx_data;
          else               rsp_data_d[2*Data_width-1:Data_width] = rx_data;
          idx_d = idx_q + 2'd1;
          if ((idx_q + 2'd1) == rsp_cnt) begin
            state_d       = ST_DONE;
            done_d        = 1'b1;
            rsp_timeout_d = 1'b0;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d       = ST_DONE;
          done_d        = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      type_q        <= CMD_WR;
      addr_q        <= '0;
      wdata_q       <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      fun_q         <= '0;
      rsp_data_q    <= '0;
      done_q        <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rx_unexp_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      type_q        <= type_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      fun_q         <= fun_d;
      rsp_data_q    <= rsp_data_d;
      done_q        <= done_d;
      rsp_timeout_q <= rsp_timeout_d;
      rx_unexp_q    <= rx_unexp_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign tx_valid    = (state_q == ST_SEND);
  assign tx_data     = tx_valid ? frame_byte : '0;
  assign rsp_data    = rsp_data_q;
  assign done        = done_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rx_unexp    = rx_unexp_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host: frame bytes, response capture, timeout,
// unexpected rx bytes and mid-command reset.
module tb_uart_cmd_host;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_wdata, cmd_opa, cmd_opb;
  logic [3:0]  cmd_fun;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] rsp_data;
  logic        done, rsp_timeout, rx_unexp;

  int n_cmp = 0;
  int n_err = 0;

  uart_cmd_host #(
    .Data_width(8), .DEPTH(16), .NUM_OF_OPERATIONS(16), .TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RST(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_opa(cmd_opa),
    .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_data(rsp_data), .done(done), .rsp_timeout(rsp_timeout), .rx_unexp(rx_unexp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] alu_frame [4];
    alu_frame[0] = 8'hCC; alu_frame[1] = 8'h10; alu_frame[2] = 8'h20; alu_frame[3] = 8'h00;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = '0;
    cmd_wdata = '0; cmd_opa = '0; cmd_opb = '0; cmd_fun = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tick(); tick();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_rx_unexp", 32'(rx_unexp), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);

    // WR addr 5 data 0x3C, tx_ready held high
    tx_ready = 1'b1; cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 4'd5; cmd_wdata = 8'h3C;
    tick();
    cmd_valid = 1'b0;
    chk("wr_b0_valid", 32'(tx_valid), 1);
    chk("wr_b0", 32'(tx_data), 32'hAA);
    chk("wr_busy_ready", 32'(cmd_ready), 0);
    tick(); chk("wr_b1", 32'(tx_data), 32'h05);
    tick(); chk("wr_b2", 32'(tx_data), 32'h3C);
    tick();
    chk("wr_done", 32'(done), 1);
    chk("wr_timeout", 32'(rsp_timeout), 0);
    chk("wr_rsp", 32'(rsp_data), 0);
    chk("wr_txv_off", 32'(tx_valid), 0);
    tick();
    chk("wr_done_pulse", 32'(done), 0);
    chk("wr_ready_back", 32'(cmd_ready), 1);

    // RD addr 2, response 0x7E after 20 cycles
    cmd_valid = 1'b1; cmd_type = 2'd1; cmd_addr = 4'd2;
    tick();
    cmd_valid = 1'b0;
    chk("rd_b0", 32'(tx_data), 32'hBB);
    tick(); chk("rd_b1", 32'(tx_data), 32'h02);
    tick(); chk("rd_wait_txv", 32'(tx_valid), 0);
    for (int i = 0; i < 19; i++) tick();
    chk("rd_no_early_done", 32'(done), 0);
    rx_valid = 1'b1; rx_data = 8'h7E;
    tick();
    rx_valid = 1'b0;
    chk("rd_done", 32'(done), 1);
    chk("rd_rsp", 32'(rsp_data), 32'h007E);
    chk("rd_timeout", 32'(rsp_timeout), 0);
    chk("rd_no_unexp", 32'(rx_unexp), 0);
    tick();

    // ALU_OP with tx_ready stalling every other cycle; cmd_valid held during SEND
    tx_ready = 1'b0;
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_opa = 8'h10; cmd_opb = 8'h20; cmd_fun = 4'd0;
    tick();
    cmd_type = 2'd1; cmd_addr = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tx_ready = 1'b0;
      chk("alu_byte", 32'(tx_data), 32'(alu_frame[i]));
      chk("alu_busy_ready", 32'(cmd_ready), 0);
      tick();
      chk("alu_stall_hold", 32'(tx_data), 32'(alu_frame[i]));
      chk("alu_stall_valid", 32'(tx_valid), 1);
      if (i == 1) cmd_valid = 1'b0;
      tx_ready = 1'b1;
      tick();
    end
    tx_ready = 1'b0;
    chk("alu_wait_txv", 32'(tx_valid), 0);
    rx_valid = 1'b1; rx_data = 8'h30;
    tick();
    rx_data = 8'h00;
    chk("alu_mid_done", 32'(done), 0);
    tick();
    rx_valid = 1'b0;
    chk("alu_done", 32'(done), 1);
    chk("alu_rsp", 32'(rsp_data), 32'h0030);
    chk("alu_timeout", 32'(rsp_timeout), 0);
    tick();

    // ALU_NOP fun 2: one response byte, then silence until timeout
    tx_ready = 1'b1;
    cmd_valid = 1'b1; cmd_type = 2'd3; cmd_fun = 4'd2;
    tick();
    cmd_valid = 1'b0;
    chk("nop_b0", 32'(tx_data), 32'hDD);
    tick(); chk("nop_b1", 32'(tx_data), 32'h02);
    tick();
    rx_valid = 1'b1; rx_data = 8'h5A;
    tick();
    rx_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == 1 || k == TO) chk("nop_no_early_done", 32'(done), 0);
    end
    tick();
    chk("nop_done", 32'(done), 1);
    chk("nop_timeout", 32'(rsp_timeout), 1);
    chk("nop_rsp", 32'(rsp_data), 32'h005A);
    tick();
    chk("nop_rsp_held", 32'(rsp_data), 32'h005A);
    chk("nop_timeout_held", 32'(rsp_timeout), 1);

    // rx byte while idle
    rx_valid = 1'b1; rx_data = 8'hEE;
    tick();
    rx_valid = 1'b0;
    chk("idle_unexp", 32'(rx_unexp), 1);
    chk("idle_ready", 32'(cmd_ready), 1);
    chk("idle_rsp_kept", 32'(rsp_data), 32'h005A);
    tick();
    chk("idle_unexp_pulse", 32'(rx_unexp), 0);

    // reset while sending the second frame byte
    cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 4'd7; cmd_wdata = 8'h11;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_mid_b1", 32'(tx_data), 32'h07);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_txv", 32'(tx_valid), 0);
    chk("rst_mid_done", 32'(done), 0);
    rst_n = 1'b1;
    chk("rst_mid_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid_no_done", 32'(done), 0);
    end
    chk("rst_mid_rsp", 32'(rsp_data), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
